// File: rtl/stream_demux.sv
// stream_demux: packet-aware 1-to-N valid/ready stream demultiplexer.
// The first beat of each packet picks its output channel through in_sel.
// The packet stays locked to that channel until the beat carrying in_last is accepted.
// Each output channel has a one-entry register, so every consumer drains independently.
// Beats whose first in_sel is out of range are swallowed up to and including in_last.
// Optional feature: define STREAM_DEMUX_DROP_CNT_EN to add the drop_count port.
// drop_count is an 8-bit saturating count of discarded beats.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_last,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic               busy,
    output logic               err
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

    state_t            state_q, state_d;
    logic [SELW-1:0]   dest_q;
    logic              err_q, err_d;
    logic              lock_dest;
    logic              drop_beat;
    logic              sel_ok;
    logic [SELW-1:0]   tgt;
    logic              tgt_ok;
    logic              accept;
    logic [N-1:0]      load;

    assign sel_ok = ({1'b0, in_sel} < NUM_CH);
    assign accept = in_valid & in_ready;
    assign busy   = (state_q != IDLE);
    assign err    = err_q;

    // Target channel: live in_sel on a first beat, locked destination mid-packet
    always_comb begin
        tgt    = in_sel;
        tgt_ok = 1'b0;
        case (state_q)
            IDLE:    begin tgt = in_sel; tgt_ok = sel_ok; end
            BURST:   begin tgt = dest_q; tgt_ok = 1'b1;   end
            default: begin tgt = in_sel; tgt_ok = 1'b0;   end
        endcase
        // A discarded beat is always accepted; a routed beat needs room in its channel
        in_ready = tgt_ok ? (~out_valid[tgt] | out_ready[tgt]) : 1'b1;
    end

    // One-hot load strobe for the channel receiving the accepted beat
    always_comb begin
        load = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept & tgt_ok & (tgt == SELW'(k));
        end
    end

    // Packet FSM next state, error pulse and drop detection
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        lock_dest = 1'b0;
        drop_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        if (!in_last) begin
                            state_d   = BURST;
                            lock_dest = 1'b1;
                        end
                    end else begin
                        err_d     = 1'b1;
                        drop_beat = 1'b1;
                        if (!in_last) state_d = DROP;
                    end
                end
            end
            BURST: begin
                if (accept && in_last) state_d = IDLE;
            end
            DROP: begin
                if (accept) begin
                    drop_beat = 1'b1;
                    if (in_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, locked destination and registered error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (lock_dest) dest_q <= in_sel;
        end
    end

    // Per-channel output register: a new beat wins over a same-cycle drain
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]  <= in_data;
                    out_last[k]                 <= in_last;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Saturating count of discarded beats
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (drop_beat && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_beat;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: randomized and directed bench for stream_demux.
// It drives an N=4 and an N=3 instance from the same inputs.
// The N=3 instance is the one that can see out-of-range selects.
module tb_stream_demux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic        in_valid;
    logic [3:0]  out_ready;

    logic [31:0] o4_data;
    logic [3:0]  o4_last, o4_valid;
    logic        o4_ready, o4_busy, o4_err;
    logic [23:0] o3_data;
    logic [2:0]  o3_last, o3_valid;
    logic        o3_ready, o3_busy, o3_err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0]  o4_drop, o3_drop;
`endif

    stream_demux #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_last(in_last), .in_valid(in_valid), .in_ready(o4_ready),
        .out_data(o4_data), .out_last(o4_last), .out_valid(o4_valid),
        .out_ready(out_ready), .busy(o4_busy), .err(o4_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_count(o4_drop)
`endif
    );

    stream_demux #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_last(in_last), .in_valid(in_valid), .in_ready(o3_ready),
        .out_data(o3_data), .out_last(o3_last), .out_valid(o3_valid),
        .out_ready(out_ready[2:0]), .busy(o3_busy), .err(o3_err)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_count(o3_drop)
`endif
    );

    // Observed view of whichever instance is under test
    logic        use3;
    logic [31:0] obs_data;
    logic [3:0]  obs_last, obs_valid;
    logic        obs_ready, obs_busy, obs_err;
    assign obs_data  = use3 ? {8'h00, o3_data}  : o4_data;
    assign obs_last  = use3 ? {1'b0, o3_last}   : o4_last;
    assign obs_valid = use3 ? {1'b0, o3_valid}  : o4_valid;
    assign obs_ready = use3 ? o3_ready : o4_ready;
    assign obs_busy  = use3 ? o3_busy  : o4_busy;
    assign obs_err   = use3 ? o3_err   : o4_err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0]  obs_drop;
    assign obs_drop  = use3 ? o3_drop : o4_drop;
`endif

    // Reference model: per-channel beat queues plus packet bookkeeping
    int          mn;
    logic [8:0]  mq [4][$];
    bit          m_inpkt, m_dropping, m_err;
    int          m_dest, m_drop;
    int          checks, passes;
    logic        got_rdy, want_rdy;

    task automatic m_reset();
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_inpkt = 0; m_dropping = 0; m_err = 0; m_dest = 0; m_drop = 0;
    endtask

    function automatic logic m_ready();
        int t;
        if (m_dropping) return 1'b1;
        if (m_inpkt) t = m_dest;
        else if (int'(in_sel) >= mn) return 1'b1;
        else t = int'(in_sel);
        return (mq[t].size() == 0) || out_ready[t];
    endfunction

    task automatic m_clock();
        logic acc;
        acc = in_valid & m_ready();
        m_err = 0;
        for (int k = 0; k < mn; k++)
            if (mq[k].size() > 0 && out_ready[k]) void'(mq[k].pop_front());
        if (acc) begin
            if (m_dropping) begin
                if (m_drop < 255) m_drop++;
                if (in_last) m_dropping = 0;
            end else if (m_inpkt) begin
                mq[m_dest].push_back({in_last, in_data});
                if (in_last) m_inpkt = 0;
            end else if (int'(in_sel) >= mn) begin
                m_err = 1;
                if (m_drop < 255) m_drop++;
                m_dropping = !in_last;
            end else begin
                mq[in_sel].push_back({in_last, in_data});
                if (!in_last) begin
                    m_inpkt = 1;
                    m_dest  = int'(in_sel);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        m_reset();
        #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus: ready sampled mid-cycle, outputs settle 1ns after the edge
    task automatic drive(input logic v, input logic [1:0] s, input logic l, input logic [7:0] d);
        in_valid = v; in_sel = s; in_last = l; in_data = d;
        @(negedge clk);
        got_rdy  = obs_ready;
        want_rdy = m_ready();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic test_reset();
        use3 = 0; mn = 4; out_ready = 4'h0; in_sel = 2'd0;
        do_reset();
        checks++; if (obs_valid !== 4'h0) $display("FAIL reset_valid got %b want 0000", obs_valid); else passes++;
        checks++; if (obs_data !== 32'h0) $display("FAIL reset_data got %h want 0", obs_data); else passes++;
        checks++; if (obs_last !== 4'h0) $display("FAIL reset_last got %b want 0000", obs_last); else passes++;
        checks++; if (obs_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", obs_busy); else passes++;
        checks++; if (obs_err !== 1'b0) $display("FAIL reset_err got %b want 0", obs_err); else passes++;
        checks++; if (obs_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", obs_ready); else passes++;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        checks++; if (obs_drop !== 8'd0) $display("FAIL reset_drop got %0d want 0", obs_drop); else passes++;
`endif
    endtask

    task automatic test_single();
        out_ready = 4'hF;
        drive(1'b1, 2'd2, 1'b1, 8'hA5);
        checks++; if (got_rdy !== 1'b1) $display("FAIL single_ready got %b want 1", got_rdy); else passes++;
        checks++; if (obs_valid !== 4'b0100) $display("FAIL single_valid got %b want 0100", obs_valid); else passes++;
        checks++; if (obs_data[23:16] !== 8'hA5) $display("FAIL single_data got %h want a5", obs_data[23:16]); else passes++;
        checks++; if (obs_last[2] !== 1'b1) $display("FAIL single_last got %b want 1", obs_last[2]); else passes++;
        checks++; if (obs_busy !== 1'b0) $display("FAIL single_busy got %b want 0", obs_busy); else passes++;
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        checks++; if (obs_valid !== 4'b0000) $display("FAIL single_drain got %b want 0000", obs_valid); else passes++;
    endtask

    task automatic test_burst();
        logic [7:0] bd [3] = '{8'h11, 8'h22, 8'h33};
        logic [1:0] bs [3] = '{2'd1, 2'd3, 2'd3};
        logic       bl [3] = '{1'b0, 1'b0, 1'b1};
        logic       bb [3] = '{1'b1, 1'b1, 1'b0};
        out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bs[i], bl[i], bd[i]);
            checks++; if (got_rdy !== 1'b1) $display("FAIL burst_ready[%0d] got %b want 1", i, got_rdy); else passes++;
            checks++; if (obs_valid !== 4'b0010) $display("FAIL burst_valid[%0d] got %b want 0010", i, obs_valid); else passes++;
            checks++; if (obs_data[15:8] !== bd[i]) $display("FAIL burst_data[%0d] got %h want %h", i, obs_data[15:8], bd[i]); else passes++;
            checks++; if (obs_last[1] !== bl[i]) $display("FAIL burst_last[%0d] got %b want %b", i, obs_last[1], bl[i]); else passes++;
            checks++; if (obs_busy !== bb[i]) $display("FAIL burst_busy[%0d] got %b want %b", i, obs_busy, bb[i]); else passes++;
        end
        drive(1'b0, 2'd0, 1'b0, 8'h00);
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1110;
        drive(1'b1, 2'd0, 1'b0, 8'h44);
        checks++; if (got_rdy !== 1'b1) $display("FAIL bp_first_ready got %b want 1", got_rdy); else passes++;
        checks++; if (obs_valid[0] !== 1'b1) $display("FAIL bp_first_valid got %b want 1", obs_valid[0]); else passes++;
        checks++; if (obs_data[7:0] !== 8'h44) $display("FAIL bp_first_data got %h want 44", obs_data[7:0]); else passes++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd2, 1'b1, 8'h55);
            checks++; if (got_rdy !== 1'b0) $display("FAIL bp_hold_ready[%0d] got %b want 0", i, got_rdy); else passes++;
            checks++; if (obs_data[7:0] !== 8'h44) $display("FAIL bp_hold_data[%0d] got %h want 44", i, obs_data[7:0]); else passes++;
            checks++; if (obs_busy !== 1'b1) $display("FAIL bp_hold_busy[%0d] got %b want 1", i, obs_busy); else passes++;
        end
        out_ready = 4'hF;
        drive(1'b1, 2'd2, 1'b1, 8'h55);
        checks++; if (got_rdy !== 1'b1) $display("FAIL bp_release_ready got %b want 1", got_rdy); else passes++;
        checks++; if (obs_valid !== 4'b0001) $display("FAIL bp_release_valid got %b want 0001", obs_valid); else passes++;
        checks++; if (obs_data[7:0] !== 8'h55) $display("FAIL bp_release_data got %h want 55", obs_data[7:0]); else passes++;
        checks++; if (obs_last[0] !== 1'b1) $display("FAIL bp_release_last got %b want 1", obs_last[0]); else passes++;
        drive(1'b0, 2'd0, 1'b0, 8'h00);
    endtask

    task automatic test_drop();
        use3 = 1; mn = 3; out_ready = 4'hF;
        do_reset();
        drive(1'b1, 2'd3, 1'b0, 8'h77);
        checks++; if (got_rdy !== 1'b1) $display("FAIL drop_ready got %b want 1", got_rdy); else passes++;
        checks++; if (obs_err !== 1'b1) $display("FAIL drop_err_pulse got %b want 1", obs_err); else passes++;
        checks++; if (obs_busy !== 1'b1) $display("FAIL drop_busy1 got %b want 1", obs_busy); else passes++;
        checks++; if (obs_valid !== 4'h0) $display("FAIL drop_valid1 got %b want 0000", obs_valid); else passes++;
        drive(1'b1, 2'($urandom_range(0, 2)), 1'b0, 8'h78);
        checks++; if (obs_err !== 1'b0) $display("FAIL drop_err2 got %b want 0", obs_err); else passes++;
        checks++; if (obs_busy !== 1'b1) $display("FAIL drop_busy2 got %b want 1", obs_busy); else passes++;
        checks++; if (obs_valid !== 4'h0) $display("FAIL drop_valid2 got %b want 0000", obs_valid); else passes++;
        drive(1'b1, 2'd0, 1'b1, 8'h79);
        checks++; if (obs_err !== 1'b0) $display("FAIL drop_err3 got %b want 0", obs_err); else passes++;
        checks++; if (obs_busy !== 1'b0) $display("FAIL drop_busy3 got %b want 0", obs_busy); else passes++;
        checks++; if (obs_valid !== 4'h0) $display("FAIL drop_valid3 got %b want 0000", obs_valid); else passes++;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        checks++; if (obs_drop !== 8'd3) $display("FAIL drop_count got %0d want 3", obs_drop); else passes++;
        drive(1'b1, 2'd3, 1'b0, 8'h00);
        for (int i = 0; i < 260; i++) drive(1'b1, 2'd1, 1'b0, 8'(i));
        drive(1'b1, 2'd1, 1'b1, 8'h00);
        checks++; if (obs_drop !== 8'd255) $display("FAIL drop_count_sat got %0d want 255", obs_drop); else passes++;
`endif
        drive(1'b0, 2'd0, 1'b0, 8'h00);
        use3 = 0; mn = 4;
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_ready = 4'h0;
        drive(1'b1, 2'd2, 1'b0, 8'hC2);
        checks++; if (obs_valid !== 4'b0100) $display("FAIL rmid_hold got %b want 0100", obs_valid); else passes++;
        checks++; if (obs_busy !== 1'b1) $display("FAIL rmid_busy got %b want 1", obs_busy); else passes++;
        do_reset();
        checks++; if (obs_valid !== 4'h0) $display("FAIL rmid_valid got %b want 0000", obs_valid); else passes++;
        checks++; if (obs_busy !== 1'b0) $display("FAIL rmid_idle got %b want 0", obs_busy); else passes++;
        out_ready = 4'hF;
        drive(1'b1, 2'd1, 1'b1, 8'h5A);
        checks++; if (obs_valid !== 4'b0010) $display("FAIL rmid_route got %b want 0010", obs_valid); else passes++;
        checks++; if (obs_data[15:8] !== 8'h5A) $display("FAIL rmid_data got %h want 5a", obs_data[15:8]); else passes++;
        drive(1'b0, 2'd0, 1'b0, 8'h00);
    endtask

    task automatic test_stall_stream();
        logic [7:0] d;
        out_ready = 4'b0000;
        drive(1'b1, 2'd1, 1'b1, 8'hB1);
        out_ready = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            drive(1'b1, (i == 0) ? 2'd3 : 2'($urandom), (i == 4), d);
            checks++; if (got_rdy !== 1'b1) $display("FAIL stall_ready[%0d] got %b want 1", i, got_rdy); else passes++;
            checks++; if (obs_valid !== 4'b1010) $display("FAIL stall_valid[%0d] got %b want 1010", i, obs_valid); else passes++;
            checks++; if (obs_data[31:24] !== d) $display("FAIL stall_ch3[%0d] got %h want %h", i, obs_data[31:24], d); else passes++;
            checks++; if (obs_data[15:8] !== 8'hB1) $display("FAIL stall_ch1[%0d] got %h want b1", i, obs_data[15:8]); else passes++;
        end
        out_ready = 4'hF;
        drive(1'b0, 2'd0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int pass = 0; pass < 2; pass++) begin
            use3 = (pass == 1); mn = (pass == 1) ? 3 : 4;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                out_ready = 4'($urandom);
                drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 2) == 0, 8'($urandom));
                checks++; if (got_rdy !== want_rdy) $display("FAIL rand_ready n%0d c%0d got %b want %b", mn, c, got_rdy, want_rdy); else passes++;
                checks++; if (obs_busy !== (m_inpkt | m_dropping)) $display("FAIL rand_busy n%0d c%0d got %b want %b", mn, c, obs_busy, m_inpkt | m_dropping); else passes++;
                checks++; if (obs_err !== m_err) $display("FAIL rand_err n%0d c%0d got %b want %b", mn, c, obs_err, m_err); else passes++;
                for (int k = 0; k < mn; k++) begin
                    checks++; if (obs_valid[k] !== (mq[k].size() > 0)) $display("FAIL rand_valid n%0d c%0d ch%0d got %b want %b", mn, c, k, obs_valid[k], mq[k].size() > 0); else passes++;
                    if (mq[k].size() > 0) begin
                        checks++; if ({obs_last[k], obs_data[k*8 +: 8]} !== mq[k][0]) $display("FAIL rand_beat n%0d c%0d ch%0d got %h want %h", mn, c, k, {obs_last[k], obs_data[k*8 +: 8]}, mq[k][0]); else passes++;
                    end
                end
`ifdef STREAM_DEMUX_DROP_CNT_EN
                checks++; if (obs_drop !== 8'(m_drop)) $display("FAIL rand_drop n%0d c%0d got %0d want %0d", mn, c, obs_drop, m_drop); else passes++;
`endif
            end
        end
        use3 = 0; mn = 4;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_last = 1'b0; in_data = 8'h00;
        out_ready = 4'h0; use3 = 0; mn = 4; checks = 0; passes = 0;
        m_reset();
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_stall_stream();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
